mem_arbiter: RTL
================

# mem_arbiter

Round-robin arbiter that shares the single external memory port between `NUM_REQ` cache-side requesters, such as the CPU cache and the mini-GPU cache. Every requester and the memory side use the same addr/rd/wr/wdata/rdata/ready protocol. The arbiter registers the winning request onto the memory port, waits for `mem_ready`, and returns a one-cycle ready pulse with the read data. A per-requester lock keeps the grant across a cache-line burst, with a bounded hold count so no requester can starve the others.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (≥2).
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `MAX_HOLD`, 4, maximum consecutive transactions one owner may complete under lock (≥1).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_addr`  in  [NUM_REQ][ADDR_WIDTH]  per-requester address.
- `req_rd`  in  [NUM_REQ]  read request, level, held until ready.
- `req_wr`  in  [NUM_REQ]  write request, level, held until ready.
- `req_wdata`  in  [NUM_REQ][DATA_WIDTH]  write data.
- `req_lock`  in  [NUM_REQ]  requests continued ownership after the current transaction.
- `req_rdata`  out  DATA_WIDTH  read data, shared bus, valid only with `req_ready`.
- `req_ready`  out  [NUM_REQ]  one-cycle completion pulse, one-hot or zero.
- `grant`  out  [NUM_REQ]  one-hot current owner, zero when idle.
- `mem_addr`  out  ADDR_WIDTH  memory address (registered).
- `mem_rd`  out  1  memory read strobe (registered).
- `mem_wr`  out  1  memory write strobe (registered).
- `mem_wdata`  out  DATA_WIDTH  memory write data (registered).
- `mem_rdata`  in  DATA_WIDTH  memory read data.
- `mem_ready`  in  1  memory completion, sampled only in ISSUE.

## Operation
- **States:**
  - `ARB_IDLE`: samples requests.
  - `ARB_ISSUE`: drives the memory port and waits for `mem_ready`.
  - `ARB_RESP`: pulses `req_ready[owner]`.
- **IDLE → ISSUE.** Taken when any `req_rd|req_wr` is high.
  - Winner selection:
    - If the lock is active and the owner requests, the owner wins.
    - Otherwise the first requester at or above `(last_owner+1) mod NUM_REQ` wins, wrapping.
  - Registered on the same edge: `mem_addr`/`mem_wdata` from the winner; `mem_wr` = `req_wr[w]`; `mem_rd` = `req_rd[w] & ~req_wr[w]` (both asserted is illegal and is issued as a write).
  - Also registered: `grant`; `last_owner` = w.
- **ISSUE → RESP.** Taken when `mem_ready`=1.
  - `req_rdata` ← `mem_rdata`, `req_ready[owner]` ← 1, `mem_rd`/`mem_wr` ← 0.
  - `mem_addr`/`mem_wdata` hold their values.
- **RESP → IDLE.** Always.
  - `req_ready` returns to 0.
  - Lock evaluation, using `req_lock[owner]` sampled in RESP:
    - If `req_lock[owner]` = 1 and `hold_cnt` < `MAX_HOLD`-1: `lock_active` ← 1, `hold_cnt`++.
    - Otherwise: `lock_active` ← 0, `hold_cnt` ← 0.
- **Lock release in IDLE.** If `lock_active` and the owner is not requesting, the lock drops and normal round-robin applies. `hold_cnt` resets whenever the owner changes.
- **`grant`** stays set from ISSUE through RESP and clears in IDLE.
- **Ignored inputs:** requests from non-owners during ISSUE/RESP; `mem_ready` outside ISSUE.
- **Requester rule:** after seeing `req_ready`, a requester drops its request or presents its next one on the following edge. IDLE only ever sees post-completion values.

## Timing
- **Reset:**
  - State ARB_IDLE.
  - All outputs 0.
  - `last_owner` = `NUM_REQ`-1, so requester 0 has first priority.
  - `lock_active`=0, `hold_cnt`=0.
- **Latency.** Request visible in IDLE at cycle 0 → `mem_rd`/`mem_wr` high at cycle 1. If `mem_ready` is first high at cycle k≥1, `req_ready` pulses at cycle k+1 and IDLE is at cycle k+2.
- **Throughput.** Minimum 3 cycles per transaction.
- **Hold guarantee.** `mem_addr`, `mem_wdata` and the strobe stay constant throughout ISSUE.
- **Reset mid-transaction.** The transaction is abandoned; strobes drop immediately (asynchronously) and no `req_ready` is issued.

## Structure
- **Package `mem_arb_pkg`:** `arb_state_t` enum (ARB_IDLE, ARB_ISSUE, ARB_RESP) and `clog2`-based owner-index width helper.
- **Sub-module `rr_picker`:** combinational; inputs request vector, `last_owner`, `lock_active`/owner; outputs winner index and valid.

## Test plan
1. **Single read.** req0 reads 0x100; `mem_ready` high at cycle 3 with 0xDEADBEEF → `mem_rd`=1 on cycles 1–3, `mem_addr`=0x100, `req_ready[0]` and `req_rdata`=0xDEADBEEF at cycle 4.
2. **Write.** req1 writes 0x12345678 to 0x200; `mem_ready` at cycle 1 → `mem_wr`=1 with that data at cycle 1, `mem_rd`=0, `req_ready[1]` at cycle 2.
3. **Fairness.** req0 and req1 both request continuously after reset, no lock → grants alternate 0,1,0,1 over 4 transactions.
4. **Lock burst.** `MAX_HOLD`=4; req1 locked for 4 refill reads while req0 pends → 4 consecutive req1 grants, then req0.
5. **Starvation bound.** `MAX_HOLD`=2; req1 holds lock continuously while req0 pends → req1, req1, req0, req1, req1.
6. **Reset mid-ISSUE.** `rst_n` pulsed low with `mem_ready`=0 → `mem_rd` 0 immediately, no `req_ready`; with both requesting after reset, req0 is granted first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory-port arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   owner_w()    - index width for a vector of n entries (never below 1 bit)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Width of an index into n entries; a 1-entry space still needs a 1-bit field.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus of the arbiter.
//   Requester side: req_addr/req_rd/req_wr/req_wdata/req_lock (per requester, in)
//                   req_rdata (shared), req_ready, grant (out of arbiter)
//   Memory side:    mem_addr/mem_rd/mem_wr/mem_wdata (out of arbiter)
//                   mem_rdata/mem_ready (into arbiter)
// Modports: slave  - the arbiter's view
//           master - the environment's view (requesters + memory model)
interface mem_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]                 req_rd;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_lock;
    logic [DATA_WIDTH-1:0]              req_rdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 grant;

    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic                               mem_rd;
    logic                               mem_wr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic [DATA_WIDTH-1:0]              mem_rdata;
    logic                               mem_ready;

    modport slave (
        input  req_addr, req_rd, req_wr, req_wdata, req_lock,
        output req_rdata, req_ready, grant,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output req_addr, req_rd, req_wr, req_wdata, req_lock,
        input  req_rdata, req_ready, grant,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req        - per-requester request (rd|wr)
//   last_owner - index of the most recent winner
//   lock_hold  - current owner holds a live lock and is requesting
//   win_idx    - selected requester (only meaningful with win_vld)
//   win_vld    - at least one request present
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    input  logic               lock_hold,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    int               cand_i;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        win_vld = |req;
        win_idx = last_owner;
        cand_i  = 0;
        cand    = '0;
        // A live lock keeps the grant on last_owner; otherwise scan upward
        // from last_owner+1 and wrap, ending on last_owner itself.
        found   = lock_hold;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_i = (int'(last_owner) + k) % NUM_REQ;
            cand   = IDX_W'(cand_i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port among NUM_REQ requesters.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mem_arbiter_if.slave: requester request/response lines and
//                the registered memory port
// Flow: IDLE picks a winner and registers its request onto the memory port,
// ISSUE holds it until mem_ready, RESP pulses req_ready[owner] with the read
// data and decides whether the owner keeps a lock for its next transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int IDX_W  = owner_w(NUM_REQ);
    localparam int HOLD_W = owner_w(MAX_HOLD);

    arb_state_t state, state_nxt;
    logic       issue_go, resp_go;

    logic [NUM_REQ-1:0]    req_vec;
    logic [IDX_W-1:0]      last_owner;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_vld;
    logic                  owner_req;
    logic                  lock_active;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  lock_keep;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_rd_q, mem_wr_q;
    logic [DATA_WIDTH-1:0] req_rdata_q;
    logic [NUM_REQ-1:0]    req_ready_q;
    logic [NUM_REQ-1:0]    grant_q;

    assign req_vec   = bus.req_rd | bus.req_wr;
    assign owner_req = req_vec[last_owner];

    // last_owner doubles as the current owner from ISSUE through RESP.
    // Lock is extended only while the owner's run stays below MAX_HOLD.
    assign lock_keep = bus.req_lock[last_owner] && (int'(hold_cnt) < MAX_HOLD - 1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_vec),
        .last_owner (last_owner),
        .lock_hold  (lock_active & owner_req),
        .win_idx    (win_idx),
        .win_vld    (win_vld)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_go  = 1'b0;
        resp_go   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (win_vld) begin
                    state_nxt = ARB_ISSUE;
                    issue_go  = 1'b1;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_ready) begin
                    state_nxt = ARB_RESP;
                    resp_go   = 1'b1;
                end
            end
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // ---------------- memory port ----------------
    // Address/data load only on issue, so they hold through ISSUE and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else if (issue_go) begin
            mem_addr_q  <= bus.req_addr[win_idx];
            mem_wdata_q <= bus.req_wdata[win_idx];
            // rd and wr together is illegal; it goes out as a write.
            mem_wr_q    <= bus.req_wr[win_idx];
            mem_rd_q    <= bus.req_rd[win_idx] & ~bus.req_wr[win_idx];
        end else if (resp_go) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end
    end

    // ---------------- requester response ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rdata_q <= '0;
            req_ready_q <= '0;
        end else begin
            req_ready_q <= '0;
            if (resp_go) begin
                req_rdata_q <= bus.mem_rdata;
                req_ready_q <= NUM_REQ'(1) << last_owner;
            end
        end
    end

    // ---------------- ownership / lock ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            lock_active <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Owner walked away: the lock is gone even if nobody else asks.
                    if (lock_active && !owner_req) begin
                        lock_active <= 1'b0;
                        hold_cnt    <= '0;
                    end
                    if (issue_go) begin
                        grant_q    <= NUM_REQ'(1) << win_idx;
                        last_owner <= win_idx;
                        if (win_idx != last_owner) hold_cnt <= '0;
                    end
                end
                ARB_RESP: begin
                    grant_q <= '0;
                    if (lock_keep) begin
                        lock_active <= 1'b1;
                        hold_cnt    <= hold_cnt + HOLD_W'(1);
                    end else begin
                        lock_active <= 1'b0;
                        hold_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.req_rdata = req_rdata_q;
    assign bus.req_ready = req_ready_q;
    assign bus.grant     = grant_q;

endmodule
